fetch_pc_ctrl: RTL and testbench

//  Program-counter / fetch sequencer directly upstream of the instruction ROM.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pc_ctrl_jump_lut.sv | 11 +
 rtl/fetch_pc_ctrl.sv | 86 ++++++++
 tb/tb_fetch_pc_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: PC width, branch offset
// width, FSM state encoding, and the jump-target map.
package fetch_pkg;

  localparam int PC_W  = 9;
  localparam int OFF_W = 6;
  localparam int LUT_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t JUMP_TABLE [2**LUT_W] = '{
    9'd10, 9'd20, 9'd37, 9'd128, 9'd200, 9'd300, 9'd400, 9'd509
  };

endpackage

// File: rtl/fetch_pc_ctrl_jump_lut.sv
// Jump-target lookup: combinational read of JUMP_TABLE, no state.
module jump_lut
  import fetch_pkg::*;
(
  input  logic [LUT_W-1:0] idx,
  output pc_t              target
);

  assign target = JUMP_TABLE[idx];

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: registered ROM address, next PC is visible one cycle after the controls are sampled.
// Optional FETCH_INSTR_COUNT_EN adds a saturating count of PC advances in RUN.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter pc_t START_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             abs_jump,
  input  logic [OFF_W-1:0] rel_offset,
  input  logic [LUT_W-1:0] target_idx,
  input  logic             halt,
  output pc_t              prog_ctr,
  output logic             running,
  output logic             done
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [15:0]      instr_count
`endif
);

  fetch_state_t state;
  pc_t          lut_target;
  pc_t          off_ext;
  pc_t          next_pc;

  jump_lut u_jump_lut (
    .idx    (target_idx),
    .target (lut_target)
  );

  assign off_ext = {{(PC_W-OFF_W){rel_offset[OFF_W-1]}}, rel_offset};

  // Sums are truncated to PC_W, so wrap-around modulo 2**PC_W is implicit.
  always_comb begin
    next_pc = prog_ctr + pc_t'(1);
    if (branch_taken) begin
      if (abs_jump) next_pc = lut_target;
      else          next_pc = prog_ctr + off_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= START_ADDR;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state    <= RUN;
            prog_ctr <= START_ADDR;
          end
        end
        RUN: begin
          if (halt)        state    <= HALTED;
          else if (!stall) prog_ctr <= next_pc;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == HALTED);

`ifdef FETCH_INSTR_COUNT_EN
  logic advance;
  assign advance = running && !halt && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (start && !running) begin
      instr_count <= '0;
    end else if (advance && instr_count != 16'hFFFF) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: vector table plus hand sequences for reset, wrap and halt.
module tb_fetch_pc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stall, branch_taken, abs_jump, halt;
  logic [5:0] rel_offset;
  logic [2:0] target_idx;
  logic [8:0] prog_ctr;
  logic       running, done;
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .abs_jump     (abs_jump),
    .rel_offset   (rel_offset),
    .target_idx   (target_idx),
    .halt         (halt),
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done)
`ifdef FETCH_INSTR_COUNT_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, stl, br, ab;
    logic [5:0] off;
    logic [2:0] idx;
    logic       hlt;
    logic [8:0] pc;
    logic       run, dn;
  } vec_t;

  vec_t vt [19];

  task automatic drive(input logic st, stl, br, ab, input logic [5:0] off,
                       input logic [2:0] idx, input logic hlt);
    start = st; stall = stl; branch_taken = br; abs_jump = ab;
    rel_offset = off; target_idx = idx; halt = hlt;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] pc_e, input logic run_e, input logic dn_e);
    n_tests++;
    if (prog_ctr !== pc_e || running !== run_e || done !== dn_e) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d running=%b done=%b, expected pc=%0d running=%b done=%b",
               name, prog_ctr, running, done, pc_e, run_e, dn_e);
    end
  endtask

  initial begin
    //            st    stl   br    ab    off     idx   hlt   pc      run   dn
    vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd7, 1'b1, 9'd0,   1'b0, 1'b0}; // IDLE ignores all
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd0,   1'b1, 1'b0}; // start
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd1,   1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd2,   1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3C, 3'd0, 1'b0, 9'd510, 1'b1, 1'b0}; // 2 + (-4)
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd511, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd0,   1'b1, 1'b0}; // 511 + 1
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 3'd5, 1'b0, 9'd0,   1'b1, 1'b0}; // stall beats jump
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd5, 1'b0, 9'd300, 1'b1, 1'b0}; // abs jump idx 5
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h07, 3'd0, 1'b0, 9'd307, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd0, 1'b0, 9'd10,  1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3D, 3'd0, 1'b0, 9'd7,   1'b1, 1'b0}; // 10 + (-3)
    vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd8,   1'b1, 1'b0}; // start in RUN ignored
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 3'd5, 1'b1, 9'd8,   1'b0, 1'b1}; // halt beats all
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd5, 1'b0, 9'd8,   1'b0, 1'b1};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 9'd0,   1'b1, 1'b0}; // restart from HALTED
    vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h1F, 3'd0, 1'b0, 9'd31,  1'b1, 1'b0}; // max positive offset
    vt[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h20, 3'd0, 1'b0, 9'd511, 1'b1, 1'b0}; // 31 + (-32)
    vt[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd3, 1'b0, 9'd128, 1'b1, 1'b0};

    reset = 1'b1;
    nop();
    #12;
    chk("reset_state", 9'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].st, vt[i].stl, vt[i].br, vt[i].ab, vt[i].off, vt[i].idx, vt[i].hlt);
      tick();
      chk($sformatf("vec%0d", i), vt[i].pc, vt[i].run, vt[i].dn);
    end

    // Async reset mid-run at pc=37, visible without a clock edge
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd2, 1'b0);
    tick();
    chk("jump_to_37", 9'd37, 1'b1, 1'b0);
    nop();
    #3 reset = 1'b1;
    #1 chk("async_reset", 9'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0);
    tick();
    chk("restart_pc0", 9'd0, 1'b1, 1'b0);
    nop();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("restart_pc%0d", i), 9'(i), 1'b1, 1'b0);
    end

    // Sequential wrap from 509
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd7, 1'b0);
    tick();
    chk("jump_509", 9'd509, 1'b1, 1'b0);
    nop();
    tick(); chk("wrap_510", 9'd510, 1'b1, 1'b0);
    tick(); chk("wrap_511", 9'd511, 1'b1, 1'b0);
    tick(); chk("wrap_0",   9'd0,   1'b1, 1'b0);
    tick(); chk("wrap_1",   9'd1,   1'b1, 1'b0);

    // Halt at 20, held for 5 cycles while other inputs wiggle
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 3'd1, 1'b0);
    tick();
    chk("jump_20", 9'd20, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b1);
    tick();
    chk("halt_20", 9'd20, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i[0], 1'b1, i[1], 6'h05, 3'd6, 1'b0);
      tick();
      chk($sformatf("halt_hold%0d", i), 9'd20, 1'b0, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0);
    tick();
    chk("halt_restart", 9'd0, 1'b1, 1'b0);
    nop();

`ifdef FETCH_INSTR_COUNT_EN
    reset = 1'b1;
    #2 reset = 1'b0;
    n_tests++;
    if (instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_reset: got %0d, expected 0", instr_count);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0);
    tick();
    nop();
    for (int i = 0; i < 8; i++) tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0);
    tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b1);
    tick();
    chk("cnt_pc", 9'd8, 1'b0, 1'b1);
    n_tests++;
    if (instr_count !== 16'd8) begin
      n_fail++;
      $display("FAIL cnt_8: got %0d, expected 8", instr_count);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0);
    tick();
    nop();
    n_tests++;
    if (instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_clear: got %0d, expected 0", instr_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
